// File: rtl/wb_slave_interface.sv
// Wishbone classic slave fronting a local register bank.
// One WB cycle becomes one local reg_wr/reg_rd strobe. The cycle then
// ends with ack, or with err on a decode miss or a reg_ready timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no access in flight; a req is accepted when no ack/err is showing
// S_WAIT | local strobe issued; waiting for reg_ready, a timeout or an abort
// S_ACK  | completion seen; wb_ack_o is registered high on the next edge
// S_ERR  | miss or timeout; wb_err_o is registered high on the next edge
module wb_slave_interface #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          TIMEOUT    = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [ADDR_WIDTH-3:0] reg_addr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_sel,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [31:0]           reg_rdata,
  input  logic                  reg_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       we_q;
  logic       req, hit, accept;

  // Burst tags and byte-lane address bits carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  assign wb_rty_o = 1'b0;
  assign req      = wb_cyc_i & wb_stb_i;
  assign hit      = (wb_adr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  // While ack/err is showing the master still holds stb for that edge;
  // accepting it would start a phantom second access.
  assign accept   = (state_q == S_IDLE) & req & ~(wb_ack_o | wb_err_o);

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode; abort beats ready, ready beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = hit ? S_WAIT : S_ERR;
      S_WAIT: begin
        if (!wb_cyc_i)              state_d = S_IDLE;
        else if (reg_ready)         state_d = S_ACK;
        else if (cnt_q == CNT_LAST) state_d = S_ERR;
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Local request capture, one-cycle strobes and the saturating wait counter.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_sel   <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (accept && hit) begin
        reg_addr  <= wb_adr_i[ADDR_WIDTH-1:2];
        reg_wdata <= wb_dat_i;
        reg_sel   <= wb_sel_i;
        reg_wr    <= wb_we_i;
        reg_rd    <= ~wb_we_i;
        we_q      <= wb_we_i;
        cnt_q     <= '0;
      end else if (state_q == S_WAIT && cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Registered bus responses; read data only moves on a completing read.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= (state_q == S_ACK);
      wb_err_o <= (state_q == S_ERR);
      if (state_q == S_WAIT && wb_cyc_i && reg_ready && !we_q)
        wb_dat_o <= reg_rdata;
    end
  end

endmodule
